spectral_to_rgb: RTL and testbench
==================================

Name: spectral_to_rgb

Overview:
- Inverse of the pixel spectral-recovery path: projects one streamed spectral vector back onto three colour channels.
- Computes R/G/B as dot products of the spectrum with per-channel response curves.
- Sits after the recovery pipeline, for round-trip checking and display preview.
- Sequential: one sample per beat, valid/ready on both sides, three MAC pipelines, normalisation with rounding and clamping.

Parameters:
- NUMSAMPLES, 1024, spectral samples per frame (>=2)
- SAMPLEWIDTH, 16, signed spectral sample width
- COEFWIDTH, 16, signed response coefficient width
- ACCWIDTH, 48, signed accumulator width (>= SAMPLEWIDTH+COEFWIDTH+clog2(NUMSAMPLES))
- SHIFT, 24, normalisation right shift (>=1)
- OUTWIDTH, 8, unsigned colour channel width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- validIn  in  1  input beat valid
- readyIn  out  1  block accepts a beat; beat accepted when validIn&&readyIn
- sample  in  SAMPLEWIDTH  signed spectral sample
- coefRed  in  COEFWIDTH  signed red response for this sample
- coefGreen  in  COEFWIDTH  signed green response for this sample
- coefBlue  in  COEFWIDTH  signed blue response for this sample
- lastIn  in  1  producer's end-of-frame marker
- sampleIndex  out  clog2(NUMSAMPLES)  index of next expected sample, for an external coefficient ROM
- validOut  out  1  result valid
- readyOut  in  1  consumer ready; result taken when validOut&&readyOut
- red  out  OUTWIDTH  red channel
- green  out  OUTWIDTH  green channel
- blue  out  OUTWIDTH  blue channel
- frameError  out  1  lastIn mismatch in the frame that produced this result

Behaviour:
- Reset (rst low, asynchronous):
  - state=ACCUM; count, accumulators, products and error flag all zero.
  - Outputs: readyIn=0 while reset is asserted, 1 in the first cycle after release; validOut=0; red/green/blue=0; frameError=0; sampleIndex=0.
- State machine, ACCUM -> DRAIN -> RESULT -> ACCUM:
  - ACCUM: readyIn=1.
    - Each accepted beat registers three products sample*coefX (full width, signed) and increments count.
    - The beat with count==NUMSAMPLES-1 goes to DRAIN; count wraps to 0.
  - DRAIN: readyIn=0.
    - Exactly 2 cycles (product stage + accumulate stage) so the last product is accumulated.
    - Then register the outputs and enter RESULT.
  - RESULT: readyIn=0, validOut=1.
    - red/green/blue/frameError are held stable while readyOut=0.
    - On validOut&&readyOut: clear accumulators and error flag, go to ACCUM. validOut=0 and readyIn=1 the next cycle.
- Pipeline:
  - Stage 1 registers the products.
  - Stage 2 does accX += productX (sign-extended to ACCWIDTH).
  - Bubbles (validIn=0) insert no product; a per-stage valid bit gates accumulation.
- Latency: final beat accepted in cycle N -> validOut=1 in cycle N+3.
- Output arithmetic:
  - v = (accX + 2^(SHIFT-1)) >>> SHIFT, i.e. round half up.
  - Clamp v<0 to 0 and v>2^OUTWIDTH-1 to 2^OUTWIDTH-1.
- Framing:
  - Frame length is set solely by count; lastIn never terminates or extends a frame.
  - Error flag is set if lastIn=1 on an accepted beat with count!=NUMSAMPLES-1, or lastIn=0 on the beat with count==NUMSAMPLES-1.
  - The flag is sticky for the frame and presented as frameError with the result.
- sampleIndex = count; it is valid combinationally for the beat currently offered.
- Overflow: the accumulator is not saturated. ACCWIDTH sizing is the user's responsibility; intermediate wrap is not flagged.
- validIn while readyIn=0 is ignored; inputs need not be held.

Test Plan (NUMSAMPLES=4, SHIFT=4, OUTWIDTH=8):
- Basic frame:
  - Stimulus: 4 back-to-back beats, sample=16, coefs R=1/G=2/B=3, lastIn on 4th, readyOut=1.
  - Response: validOut 3 cycles after the 4th beat; red=4, green=8, blue=12, frameError=0; readyIn=1 the cycle after.
- Rounding and clamping:
  - Stimulus: sample=2, coefRed=1 (acc=8).
  - Response: red=1 (8+8=16>>4).
  - Stimulus: coefGreen=-5.
  - Response: green=0.
  - Stimulus: sample=32767, coefBlue=32767.
  - Response: blue=255.
- Backpressure and bubbles:
  - Stimulus: validIn toggled 1,0,1,0,...; readyOut=0 for 10 cycles after validOut.
  - Response: same RGB as the basic case; outputs stable; readyIn=0 throughout; one transfer on readyOut=1.
- Framing error:
  - Stimulus: lastIn on the 2nd beat, not on the 4th.
  - Response: frame still closes after 4 beats; frameError=1.
  - Stimulus: next clean frame.
  - Response: frameError=0.
- Reset mid-frame:
  - Stimulus: rst low after 2 beats, asynchronously between clock edges.
  - Response: validOut/readyIn/RGB go to 0 immediately.
  - Stimulus: after release, a full frame.
  - Response: basic-case values; no residue from the prior beats.
- sampleIndex:
  - Response: reads 0,1,2,3 across accepted beats; holds during bubbles; returns to 0 after the frame.

Source files
------------

// File: rtl/spectral_to_rgb.sv
// rtl/spectral_to_rgb.sv - projects a streamed spectral vector onto normalised R/G/B channels
module spectral_to_rgb #(
    parameter int NUMSAMPLES  = 1024,
    parameter int SAMPLEWIDTH = 16,
    parameter int COEFWIDTH   = 16,
    parameter int ACCWIDTH    = 48,
    parameter int SHIFT       = 24,
    parameter int OUTWIDTH    = 8,
    localparam int IDXW       = (NUMSAMPLES > 1) ? $clog2(NUMSAMPLES) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          validIn,
    output logic                          readyIn,
    input  logic signed [SAMPLEWIDTH-1:0] sample,
    input  logic signed [COEFWIDTH-1:0]   coefRed,
    input  logic signed [COEFWIDTH-1:0]   coefGreen,
    input  logic signed [COEFWIDTH-1:0]   coefBlue,
    input  logic                          lastIn,
    output logic [IDXW-1:0]               sampleIndex,
    output logic                          validOut,
    input  logic                          readyOut,
    output logic [OUTWIDTH-1:0]           red,
    output logic [OUTWIDTH-1:0]           green,
    output logic [OUTWIDTH-1:0]           blue,
    output logic                          frameError
);

    localparam int PW = SAMPLEWIDTH + COEFWIDTH;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUMSAMPLES - 1);
    localparam logic signed [ACCWIDTH-1:0] ROUND = ACCWIDTH'(1) << (SHIFT - 1);
    localparam logic signed [ACCWIDTH-1:0] MAXV =
        {{(ACCWIDTH-OUTWIDTH){1'b0}}, {OUTWIDTH{1'b1}}};

    typedef enum logic [1:0] {ACCUM, DRAIN, RESULT} state_t;

    state_t                state, state_next;
    logic                  ready_q;
    logic                  drain_cnt;
    logic                  accept, take, is_last;
    logic [IDXW-1:0]       count;
    logic                  prod_valid;
    logic signed [PW-1:0]  prod_r, prod_g, prod_b;
    logic signed [ACCWIDTH-1:0] acc_r, acc_g, acc_b;
    logic                  err;

    // Round half up, then clamp into the unsigned channel range.
    function automatic logic [OUTWIDTH-1:0] normalise(input logic signed [ACCWIDTH-1:0] a);
        logic signed [ACCWIDTH-1:0] v;
        v = (a + ROUND) >>> SHIFT;
        if (v < 0)
            return '0;
        else if (v > MAXV)
            return '1;
        else
            return v[OUTWIDTH-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ACCUM;
            ready_q <= 1'b0;
        end else begin
            state   <= state_next;
            ready_q <= (state_next == ACCUM);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ACCUM:   if (accept && is_last) state_next = DRAIN;
            DRAIN:   if (drain_cnt) state_next = RESULT;
            RESULT:  if (take) state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    always_comb begin
        readyIn     = ready_q;
        validOut    = (state == RESULT);
        sampleIndex = count;
        accept      = validIn && ready_q;
        take        = validOut && readyOut;
        is_last     = (count == LAST_IDX);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count      <= '0;
            drain_cnt  <= 1'b0;
            prod_valid <= 1'b0;
            prod_r     <= '0;
            prod_g     <= '0;
            prod_b     <= '0;
            acc_r      <= '0;
            acc_g      <= '0;
            acc_b      <= '0;
            err        <= 1'b0;
            red        <= '0;
            green      <= '0;
            blue       <= '0;
            frameError <= 1'b0;
        end else begin
            prod_valid <= accept;
            drain_cnt  <= (state == DRAIN) ? ~drain_cnt : 1'b0;

            if (accept) begin
                prod_r <= PW'(sample) * PW'(coefRed);
                prod_g <= PW'(sample) * PW'(coefGreen);
                prod_b <= PW'(sample) * PW'(coefBlue);
                count  <= is_last ? '0 : count + 1'b1;
                if (lastIn != is_last)
                    err <= 1'b1;
            end

            if (take) begin
                acc_r <= '0;
                acc_g <= '0;
                acc_b <= '0;
                err   <= 1'b0;
            end else if (prod_valid) begin
                acc_r <= acc_r + ACCWIDTH'(prod_r);
                acc_g <= acc_g + ACCWIDTH'(prod_g);
                acc_b <= acc_b + ACCWIDTH'(prod_b);
            end

            // Second drain cycle: the final product has been accumulated.
            if (state == DRAIN && drain_cnt) begin
                red        <= normalise(acc_r);
                green      <= normalise(acc_g);
                blue       <= normalise(acc_b);
                frameError <= err;
            end
        end
    end

endmodule

// File: tb/tb_spectral_to_rgb.sv
// tb/tb_spectral_to_rgb.sv - directed self-checking bench for spectral_to_rgb
module tb_spectral_to_rgb;

    logic               clk = 1'b0;
    logic               rst;
    logic               validIn;
    logic               readyIn;
    logic signed [15:0] sample;
    logic signed [15:0] coefRed, coefGreen, coefBlue;
    logic               lastIn;
    logic [1:0]         sampleIndex;
    logic               validOut;
    logic               readyOut;
    logic [7:0]         red, green, blue;
    logic               frameError;

    int checks = 0;
    int errors = 0;

    spectral_to_rgb #(
        .NUMSAMPLES(4),
        .SAMPLEWIDTH(16),
        .COEFWIDTH(16),
        .ACCWIDTH(48),
        .SHIFT(4),
        .OUTWIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .validIn(validIn),
        .readyIn(readyIn),
        .sample(sample),
        .coefRed(coefRed),
        .coefGreen(coefGreen),
        .coefBlue(coefBlue),
        .lastIn(lastIn),
        .sampleIndex(sampleIndex),
        .validOut(validOut),
        .readyOut(readyOut),
        .red(red),
        .green(green),
        .blue(blue),
        .frameError(frameError)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic beat(input int idx, input logic signed [15:0] s, input logic signed [15:0] r,
                        input logic signed [15:0] g, input logic signed [15:0] b, input logic last);
        @(negedge clk);
        validIn = 1'b1; sample = s; coefRed = r; coefGreen = g; coefBlue = b; lastIn = last;
        check("beat_ready", 32'(readyIn), 1);
        check("beat_index", 32'(sampleIndex), 32'(idx));
    endtask

    task automatic run_frame(input string name, input logic signed [15:0] s,
                             input logic signed [15:0] r, input logic signed [15:0] g,
                             input logic signed [15:0] b, input logic [3:0] last_mask,
                             input bit bubbles, input bit hold,
                             input int er, input int eg, input int eb, input int eerr);
        readyOut = !hold;
        for (int i = 0; i < 4; i++) begin
            if (bubbles) begin
                @(negedge clk);
                validIn = 1'b0;
                check({name, "_bubble_index"}, 32'(sampleIndex), 32'(i));
            end
            beat(i, s, r, g, b, last_mask[i]);
        end
        @(negedge clk);
        validIn = 1'b0;
        check({name, "_drain1_valid"}, 32'(validOut), 0);
        check({name, "_drain1_ready"}, 32'(readyIn), 0);
        @(negedge clk);
        check({name, "_drain2_valid"}, 32'(validOut), 0);
        @(negedge clk);
        check({name, "_valid"}, 32'(validOut), 1);
        check({name, "_red"}, 32'(red), 32'(er));
        check({name, "_green"}, 32'(green), 32'(eg));
        check({name, "_blue"}, 32'(blue), 32'(eb));
        check({name, "_err"}, 32'(frameError), 32'(eerr));
        if (hold) begin
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                validIn = k[0];
                check({name, "_hold_valid"}, 32'(validOut), 1);
                check({name, "_hold_ready"}, 32'(readyIn), 0);
                check({name, "_hold_rgb"}, {8'd0, red, green, blue},
                      {8'd0, er[7:0], eg[7:0], eb[7:0]});
            end
            validIn  = 1'b0;
            readyOut = 1'b1;
        end
        @(negedge clk);
        check({name, "_after_valid"}, 32'(validOut), 0);
        check({name, "_after_ready"}, 32'(readyIn), 1);
        check({name, "_after_index"}, 32'(sampleIndex), 0);
    endtask

    initial begin
        rst = 1'b0; validIn = 1'b0; readyOut = 1'b1; lastIn = 1'b0;
        sample = '0; coefRed = '0; coefGreen = '0; coefBlue = '0;
        #12;
        check("reset_ready", 32'(readyIn), 0);
        check("reset_valid", 32'(validOut), 0);
        check("reset_rgb", {8'd0, red, green, blue}, 0);
        check("reset_err", 32'(frameError), 0);
        check("reset_index", 32'(sampleIndex), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("release_ready", 32'(readyIn), 1);

        // acc R=64,G=128,B=192 -> (acc+8)>>4
        run_frame("basic", 16, 1, 2, 3, 4'b1000, 0, 0, 4, 8, 12, 0);
        // acc R=8 rounds half up to 1; G=-40 clamps to 0; B=0
        run_frame("round", 2, 1, -5, 0, 4'b1000, 0, 0, 1, 0, 0, 0);
        // B=4*32767^2 clamps high; G negative clamps low
        run_frame("clamp", 32767, 0, -1, 32767, 4'b1000, 0, 0, 0, 0, 255, 0);
        run_frame("bubble", 16, 1, 2, 3, 4'b1000, 1, 1, 4, 8, 12, 0);
        run_frame("ferr", 16, 1, 2, 3, 4'b0010, 0, 0, 4, 8, 12, 1);
        run_frame("clean", 16, 1, 2, 3, 4'b1000, 0, 0, 4, 8, 12, 0);

        beat(0, 100, 7, 7, 7, 1'b0);
        beat(1, 100, 7, 7, 7, 1'b0);
        @(posedge clk);
        validIn = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("midrst_valid", 32'(validOut), 0);
        check("midrst_ready", 32'(readyIn), 0);
        check("midrst_rgb", {8'd0, red, green, blue}, 0);
        check("midrst_index", 32'(sampleIndex), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_release_ready", 32'(readyIn), 1);
        run_frame("postrst", 16, 1, 2, 3, 4'b1000, 0, 0, 4, 8, 12, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
